boot_status_ctrl: RTL and testbench

//  Parametrised bootloader housekeeping block. It sits beside the USB engine in the bootloader top.

---
 rtl/boot_status_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_boot_status_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/boot_status_ctrl.sv
// Bootloader housekeeping: status LED drivers on a shared PWM ramp, USB SOF
// watchdog, and a sticky boot-request FSM that drives the warm-boot primitive.
module boot_status_ctrl #(
  parameter int unsigned CLK_HZ        = 48000000,
  parameter int unsigned TICK_HZ       = 1000,
  parameter int unsigned NUM_LEDS      = 1,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned BLINK_TICKS   = 250,
  parameter int unsigned TIMEOUT_TICKS = 700,
  parameter int unsigned DRAIN_TICKS   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sof_valid,
  input  logic                  boot_req,
  input  logic [2*NUM_LEDS-1:0] led_mode,
  output logic [NUM_LEDS-1:0]   led,
  output logic                  host_present,
  output logic                  host_timeout,
  output logic                  boot,
  output logic [1:0]            boot_cause
);

  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned PRESC_W = $clog2(DIV);
  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam int unsigned WD_W    = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned DRAIN_W = $clog2(DRAIN_TICKS + 1);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_BOOT   = 2'd2;

  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_USER    = 2'b10;

  logic [PRESC_W-1:0]  presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level;
  logic                dir_up;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                blink_state;
  logic [WD_W-1:0]     wd_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [1:0]          state;
  logic [1:0]          state_next;

  logic tick_c;
  logic sof_accept_c;
  logic timeout_hit_c;
  logic drain_start_c;
  logic cause_timeout_c;

  assign tick_c        = (presc == PRESC_W'(DIV - 1));
  // SOFs stop mattering once the watchdog has fired.
  assign sof_accept_c  = sof_valid && !host_timeout;
  // The tick that carries wd_cnt onto TIMEOUT_TICKS; an SOF in the same cycle wins.
  assign timeout_hit_c = tick_c && !sof_accept_c && !host_timeout &&
                         (wd_cnt == WD_W'(TIMEOUT_TICKS - 1));

  // Tick prescaler: one-cycle tick every DIV cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
    end else if (tick_c) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  // Free-running PWM comparison counter shared by all channels.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Breathing level: triangle ramp, holding one tick at each extreme.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level  <= '0;
      dir_up <= 1'b1;
    end else if (tick_c) begin
      if (dir_up) begin
        if (level != PWM_MAX) level <= level + PWM_BITS'(1);
        else                  dir_up <= 1'b0;
      end else begin
        if (level != '0) level <= level - PWM_BITS'(1);
        else             dir_up <= 1'b1;
      end
    end
  end

  // Blink half-period counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_state <= 1'b0;
    end else if (tick_c) begin
      if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
        blink_cnt   <= '0;
        blink_state <= ~blink_state;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  // Per-channel LED drive; everything dark once in BOOT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_LEDS); i++) begin
        if (state == ST_BOOT) begin
          led[i] <= 1'b0;
        end else begin
          case (led_mode[2*i +: 2])
            2'b00:   led[i] <= 1'b0;
            2'b01:   led[i] <= 1'b1;
            2'b10:   led[i] <= (level > pwm_cnt);
            default: led[i] <= blink_state;
          endcase
        end
      end
    end
  end

  // Host watchdog: ticks since last SOF, saturating; timeout is sticky.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_cnt       <= '0;
      host_timeout <= 1'b0;
      host_present <= 1'b0;
    end else begin
      if (sof_accept_c) begin
        wd_cnt <= '0;
      end else if (tick_c && (wd_cnt != WD_W'(TIMEOUT_TICKS))) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (timeout_hit_c) begin
        host_timeout <= 1'b1;
        host_present <= 1'b0;
      end else if (sof_accept_c) begin
        host_present <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_ACTIVE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; a user request beats a same-cycle timeout.
  always_comb begin
    state_next      = state;
    drain_start_c   = 1'b0;
    cause_timeout_c = 1'b0;
    case (state)
      ST_ACTIVE: begin
        if (boot_req) begin
          state_next    = ST_DRAIN;
          drain_start_c = 1'b1;
        end else if (timeout_hit_c) begin
          state_next      = ST_BOOT;
          cause_timeout_c = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (tick_c && (drain_cnt == DRAIN_W'(DRAIN_TICKS - 1))) begin
          state_next = ST_BOOT;
        end
      end
      ST_BOOT: state_next = ST_BOOT;
      default: state_next = ST_ACTIVE;
    endcase
  end

  // Drain counter: ticks spent waiting for the last USB handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drain_cnt <= '0;
    end else if (drain_start_c) begin
      drain_cnt <= '0;
    end else if ((state == ST_DRAIN) && tick_c) begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

  // Boot cause is written only on leaving ACTIVE, so it freezes once set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      boot_cause <= 2'b00;
    end else if (drain_start_c) begin
      boot_cause <= CAUSE_USER;
    end else if (cause_timeout_c) begin
      boot_cause <= CAUSE_TIMEOUT;
    end
  end

  // Registered boot command, one cycle behind entering BOOT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      boot <= 1'b0;
    end else begin
      boot <= (state == ST_BOOT);
    end
  end

endmodule

// File: tb/tb_boot_status_ctrl.sv
// Bench for boot_status_ctrl: scoreboard of expected output snapshots,
// LED behaviour from a closed-form timing model, table-driven scenarios and
// hand-written multi-cycle corner sequences.
module tb_boot_status_ctrl;

  logic       clk;
  logic       reset;
  logic       sof_valid;
  logic       boot_req;
  logic [3:0] led_mode;
  logic [1:0] led;
  logic       host_present;
  logic       host_timeout;
  logic       boot;
  logic [1:0] boot_cause;

  boot_status_ctrl #(
    .CLK_HZ(1000), .TICK_HZ(100), .NUM_LEDS(2), .PWM_BITS(3),
    .BLINK_TICKS(2), .TIMEOUT_TICKS(5), .DRAIN_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .sof_valid(sof_valid), .boot_req(boot_req),
    .led_mode(led_mode), .led(led), .host_present(host_present),
    .host_timeout(host_timeout), .boot(boot), .boot_cause(boot_cause)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Snapshot layout: {led[1:0], host_present, host_timeout, boot, boot_cause[1:0]}
  typedef struct {
    string      name;
    logic [6:0] val;
    logic [6:0] mask;
  } exp_t;

  typedef struct {
    string      name;
    int         sof_ticks;
    int         req_tick;
    logic [6:0] val;
  } scen_t;

  exp_t  q[$];
  exp_t  ce;
  int    total  = 0;
  int    passed = 0;
  scen_t tab[6];

  function automatic logic [6:0] pk(input logic [1:0] l, input logic hp, input logic ht,
                                    input logic bt, input logic [1:0] c);
    return {l, hp, ht, bt, c};
  endfunction

  function automatic int lvl(input int t);
    int p;
    p = t % 16;
    return (p < 8) ? p : 15 - p;
  endfunction

  // Expected LED pair after edge n (n >= 1) counted from reset release.
  function automatic logic [1:0] exp_led(input logic [3:0] m, input int n);
    int mm, t, pwm, lv;
    logic bl;
    logic [1:0] r;
    mm  = n - 1;
    t   = mm / 10;
    pwm = mm % 8;
    lv  = lvl(t);
    bl  = ((t / 2) % 2) == 1;
    r   = 2'b00;
    for (int c = 0; c < 2; c++) begin
      case (m[2*c +: 2])
        2'b00:   r[c] = 1'b0;
        2'b01:   r[c] = 1'b1;
        2'b10:   r[c] = (lv > pwm);
        default: r[c] = bl;
      endcase
    end
    return r;
  endfunction

  // Scoreboard consumer: compares the snapshot after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        logic [6:0] got;
        ce  = q.pop_front();
        got = {led, host_present, host_timeout, boot, boot_cause};
        total++;
        if ((got & ce.mask) === (ce.val & ce.mask)) passed++;
        else $display("FAIL %s: got %b expected %b (mask %b) at %0t",
                      ce.name, got, ce.val, ce.mask, $time);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int expv);
    total++;
    if (got == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, expv);
  endtask

  // Drive inputs for the next edge; queue the expected snapshot when mk != 0.
  task automatic cyc(input logic rst, input logic s, input logic b, input logic [3:0] m,
                     input logic [6:0] ev, input logic [6:0] mk, input string nm);
    @(negedge clk);
    reset     = rst;
    sof_valid = s;
    boot_req  = b;
    led_mode  = m;
    if (mk != 7'h00) q.push_back('{nm, ev, mk});
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 4'b0000, 7'h00, (i == 2) ? 7'h7f : 7'h00, "reset_state");
    end
  endtask

  task automatic run_scen(input scen_t s);
    logic sv, bv;
    do_reset();
    for (int n = 1; n <= 520; n++) begin
      sv = (s.sof_ticks > 0) && ((n % (10 * s.sof_ticks)) == 5);
      bv = (s.req_tick > 0) && (n == 10 * s.req_tick + 3);
      cyc(1'b1, sv, bv, 4'b0101, s.val, (n == 520) ? 7'h7f : 7'h00, s.name);
    end
  endtask

  initial begin
    int cnt3;
    logic [6:0] ev;
    logic [6:0] mk;

    reset     = 1'b0;
    sof_valid = 1'b0;
    boot_req  = 1'b0;
    led_mode  = 4'b0000;

    tab[0] = '{"no_sof_timeout",    0, 0,  pk(2'b00, 1'b0, 1'b1, 1'b1, 2'b01)};
    tab[1] = '{"sof_every_3",       3, 0,  pk(2'b11, 1'b1, 1'b0, 1'b0, 2'b00)};
    tab[2] = '{"sof_every_4",       4, 0,  pk(2'b11, 1'b1, 1'b0, 1'b0, 2'b00)};
    tab[3] = '{"sof_every_5",       5, 0,  pk(2'b00, 1'b0, 1'b1, 1'b1, 2'b01)};
    tab[4] = '{"req_drain_timeout", 0, 3,  pk(2'b00, 1'b0, 1'b1, 1'b1, 2'b10)};
    tab[5] = '{"req_with_host",     3, 10, pk(2'b00, 1'b1, 1'b0, 1'b1, 2'b10)};

    // LEDs: ch1 breathe / ch0 solid, then ch0 blink / ch1 off, with the host kept alive.
    do_reset();
    cnt3 = 0;
    for (int n = 1; n <= 170; n++) begin
      cyc(1'b1, (n % 20) == 5, 1'b0, 4'b1001,
          pk(exp_led(4'b1001, n), n >= 5, 1'b0, 1'b0, 2'b00), 7'h7f, "breathe_solid");
      if (n >= 32 && n <= 39) cnt3 += int'(led[1]);
    end
    chk("level3_duty", cnt3, 3);
    for (int n = 171; n <= 260; n++) begin
      cyc(1'b1, (n % 20) == 5, 1'b0, 4'b0011,
          pk(exp_led(4'b0011, n), 1'b1, 1'b0, 1'b0, 2'b00), 7'h7f, "blink_off");
    end

    for (int i = 0; i < 6; i++) run_scen(tab[i]);

    // Exact timeout edge, then boot one cycle later with LEDs forced dark.
    do_reset();
    for (int n = 1; n <= 51; n++) begin
      mk = (n >= 49) ? 7'h7f : 7'h00;
      ev = (n == 49) ? pk(2'b11, 1'b0, 1'b0, 1'b0, 2'b00) :
           (n == 50) ? pk(2'b11, 1'b0, 1'b1, 1'b0, 2'b01) :
                       pk(2'b00, 1'b0, 1'b1, 1'b1, 2'b01);
      cyc(1'b1, 1'b0, 1'b0, 4'b0101, ev, mk, "timeout_edge");
    end

    // boot_req after tick 2: three drain ticks, timeout meanwhile keeps cause 10.
    do_reset();
    for (int n = 1; n <= 51; n++) begin
      mk = (n == 23 || n >= 49) ? 7'h7f : 7'h00;
      ev = (n == 23 || n == 49) ? pk(2'b11, 1'b0, 1'b0, 1'b0, 2'b10) :
           (n == 50)            ? pk(2'b11, 1'b0, 1'b1, 1'b0, 2'b10) :
                                  pk(2'b00, 1'b0, 1'b1, 1'b1, 2'b10);
      cyc(1'b1, 1'b0, n == 23, 4'b0101, ev, mk, "drain_seq");
    end

    // boot_req in the very cycle the watchdog expires.
    do_reset();
    for (int n = 1; n <= 81; n++) begin
      mk = (n == 50 || n == 80 || n == 81) ? 7'h7f : 7'h00;
      ev = (n == 81) ? pk(2'b00, 1'b0, 1'b1, 1'b1, 2'b10) :
                       pk(2'b11, 1'b0, 1'b1, 1'b0, 2'b10);
      cyc(1'b1, 1'b0, n == 50, 4'b0101, ev, mk, "req_vs_timeout");
    end

    // Reset while draining: block restarts in ACTIVE and never boots.
    do_reset();
    for (int n = 1; n <= 34; n++) begin
      cyc(1'b1, 1'b0, n == 23, 4'b0101, pk(2'b11, 1'b0, 1'b0, 1'b0, 2'b10),
          (n == 24) ? 7'h7f : 7'h00, "drain_entered");
    end
    cyc(1'b0, 1'b0, 1'b0, 4'b0101, 7'h00, 7'h00, "");
    cyc(1'b0, 1'b0, 1'b0, 4'b0101, 7'h00, 7'h7f, "reset_in_drain");
    for (int n = 1; n <= 45; n++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'b0101, pk(2'b11, 1'b0, 1'b0, 1'b0, 2'b00),
          (n == 32 || n == 45) ? 7'h7f : 7'h00, "after_drain_reset");
    end

    // SOF on a tick edge clears the watchdog; SOF after timeout is ignored.
    do_reset();
    for (int n = 1; n <= 70; n++) begin
      mk = (n == 50 || n == 59 || n == 60 || n == 70) ? 7'h7f : 7'h00;
      ev = (n <= 59) ? pk(2'b11, 1'b1, 1'b0, 1'b0, 2'b00) :
           (n == 60) ? pk(2'b11, 1'b0, 1'b1, 1'b0, 2'b01) :
                       pk(2'b00, 1'b0, 1'b1, 1'b1, 2'b01);
      cyc(1'b1, n == 10 || n == 70, 1'b0, 4'b0101, ev, mk, "sof_on_tick");
    end

    cyc(1'b1, 1'b0, 1'b0, 4'b0101, 7'h00, 7'h00, "");
    cyc(1'b1, 1'b0, 1'b0, 4'b0101, 7'h00, 7'h00, "");
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
